// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between fetch and decode
module fetch_queue #(
  parameter int DEPTH    = 8,
  parameter int WIDTH_PC = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_valid,
  input  logic [31:0]                  i_instr,
  input  logic [WIDTH_PC-1:0]          i_pc,
  output logic                         o_ready,
  input  logic                         i_en,
  output logic [31:0]                  o_instr,
  output logic [WIDTH_PC-1:0]          o_pc,
  output logic                         o_imask,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]         instr_mem [DEPTH];
  logic [WIDTH_PC-1:0] pc_mem    [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Handshakes and next-state for pointers and occupancy; flush wins over both.
  always_comb begin
    o_ready  = (count_q != CW'(DEPTH));
    o_imask  = (count_q != '0);
    push     = i_valid && o_ready && !i_flush;
    pop      = o_imask && i_en && !i_flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Control state: pointers and occupancy, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: written on an accepted push, contents never reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= i_instr;
      pc_mem[wr_ptr_q]    <= i_pc;
    end
  end

  // Head presentation; an empty queue shows a NOP at PC 0 so decode stays harmless.
  always_comb begin
    o_count = count_q;
    if (o_imask) begin
      o_instr = instr_mem[rd_ptr_q];
      o_pc    = pc_mem[rd_ptr_q];
    end else begin
      o_instr = NOP;
      o_pc    = '0;
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch unit and the decode stage.
- Absorbs fetch bursts and decode stalls by holding up to DEPTH fetched instructions with their PCs in FIFO order.
- Presents the head entry to decode as instruction word, PC and valid mask (decode's instruction-mask input).
- Supports a single-cycle flush on branch mispredict or redirect.

Parameters:
- DEPTH, 8: number of entries; power of two, ≥ 2.
- WIDTH_PC, 32: PC width carried with each instruction.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_flush  input  1  discard all entries (mispredict/redirect).
- i_valid  input  1  fetch presents an instruction this cycle.
- i_instr  input  32  fetched instruction word.
- i_pc  input  WIDTH_PC  PC of i_instr.
- o_ready  output  1  queue can accept a push this cycle (not full).
- i_en  input  1  decode consumes the head this cycle (decode stage enable / not stalled).
- o_instr  output  32  head instruction word to decode.
- o_pc  output  WIDTH_PC  PC of head instruction.
- o_imask  output  1  head entry valid (decode instruction mask).
- o_count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries {instr, pc}.
  - Write pointer and read pointer are $clog2(DEPTH) bits and wrap naturally at DEPTH.
  - Occupancy counter is held separately.
- Push: accepted when i_valid && o_ready.
  - Entry written at the write pointer; write pointer +1.
- Pop: occurs when o_imask && i_en.
  - Read pointer +1.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- o_ready = (count != DEPTH), combinational from registered count.
  - Push while full is ignored; the instruction is dropped and fetch must hold it.
- Push and pop in the same cycle while full:
  - Push is still refused, because o_ready is evaluated before the pop.
  - Pop proceeds; count becomes DEPTH−1.
- Output path, combinational from registered state:
  - o_imask = (count != 0).
  - o_instr/o_pc = entry at the read pointer when o_imask = 1.
  - When empty: o_instr = 32'h0000_0013 (NOP, addi x0,x0,0) and o_pc = 0, so decode sees a harmless opcode.
- Empty with simultaneous push:
  - Entry is written; no pop, since o_imask was 0.
  - Entry becomes visible next cycle (1-cycle minimum fetch→decode latency).
  - No bypass path.
- Flush takes priority over push and pop in the same cycle.
  - Next cycle: count = 0, read pointer = write pointer = 0, o_imask = 0, o_ready = 1.
  - A concurrent i_valid instruction is discarded.
- Reset, asynchronous, at any time including mid-burst:
  - Pointers = 0, count = 0.
  - Hence o_imask = 0, o_instr = NOP, o_pc = 0, o_ready = 1, o_count = 0.
  - Storage contents need not be reset.
- Ordering: strict FIFO. Instructions leave in exactly the order accepted; no reordering or duplication.
- Arithmetic:
  - Pointer increments are modulo DEPTH.
  - Count never exceeds DEPTH or goes below 0; this follows from the handshake qualifications and is covered by bench assertions.

Test Plan:
1. Reset, then idle → o_imask=0, o_instr=32'h00000013, o_ready=1, o_count=0; push i_instr=32'h00500093, pc=0x100 → next cycle o_imask=1, o_instr=32'h00500093, o_pc=0x100.
2. i_en=0; push 8 instructions (pc 0x0..0x1C) → o_count=8, o_ready=0; 9th push (pc 0x20) ignored; then i_en=1 for 8 cycles → pcs 0x0..0x1C emerge in order, o_imask drops after the 8th.
3. Wrap-around: fill 6 entries, pop 5, push 6 more → o_count=7; drain shows strict order across the pointer wrap; no entry lost or duplicated.
4. Queue at count=3; push and pop the same cycle → count stays 3, head advances by one. Queue full (count=8); push+pop same cycle → push refused, count=7.
5. Queue at count=5 with i_valid=1 and i_en=1; assert i_flush for one cycle → next cycle count=0, o_imask=0, o_ready=1; the flushed-cycle push is absent from subsequent output.
6. Assert i_rst asynchronously mid-burst (count=4, between clock edges) → outputs go to reset values immediately without waiting for a clock edge; after deassertion, the first push appears as head one cycle later.
